// File: rtl/kv_pkg.sv
// Shared definitions for the key/flow table: opcode and result bit positions,
// opcode decode and the XOR-fold hash used to address the table.
`timescale 1ns/1ps
package kv_pkg;

   localparam int OP_LOOKUP = 0;
   localparam int OP_INSERT = 1;
   localparam int OP_DELETE = 2;

   localparam int RES_HIT       = 0;
   localparam int RES_WRITTEN   = 1;
   localparam int RES_REMOVED   = 2;
   localparam int RES_COLLISION = 3;

   // Widest key and index the hash helper accepts.
   localparam int KV_KEY_MAX = 128;
   localparam int KV_IDX_MAX = 16;

   typedef enum logic [1:0] {OPC_NONE, OPC_LOOKUP, OPC_INSERT, OPC_DELETE} kv_op_t;
   typedef enum logic {ST_INIT, ST_RUN} kv_state_t;

   function automatic kv_op_t kv_decode(input logic [3:0] flag);
      if (flag[OP_DELETE])      return OPC_DELETE;
      else if (flag[OP_INSERT]) return OPC_INSERT;
      else if (flag[OP_LOOKUP]) return OPC_LOOKUP;
      else                      return OPC_NONE;
   endfunction

   // Key bit i lands on index bit i % aw, i.e. the aw-bit slices are XORed and
   // the short final slice is implicitly zero-padded.
   function automatic logic [KV_IDX_MAX-1:0] kv_hash(input logic [KV_KEY_MAX-1:0] key,
                                                     input int key_size = 96,
                                                     input int aw = 10);
      logic [KV_IDX_MAX-1:0] idx;
      logic [KV_KEY_MAX-1:0] k;
      idx = '0;
      k   = key;
      for (int i = 0; i < KV_KEY_MAX; i++) begin
         if (i < key_size) idx = idx ^ (KV_IDX_MAX'(k[0]) << (i % aw));
         k = k >> 1;
      end
      return idx;
   endfunction

endpackage

// File: rtl/kv_tbl_ram.sv
// Simple dual-port table storage {valid, key} with a one-cycle synchronous
// read; written so synthesis maps it onto block RAM.
`timescale 1ns/1ps
module kv_tbl_ram #(
   parameter int AW = 10,
   parameter int DW = 97
) (
   input  logic          clk156,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // NOTE: no reset on the array -- a reset would stop block-RAM inference; the
   // owning logic sweeps valid=0 through every entry instead.
   always_ff @(posedge clk156) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/kv_flow_table.sv
// Direct-mapped key table: init sweep FSM, 3-stage lookup/insert/delete
// pipeline with write forwarding, and result statistics.
`timescale 1ns/1ps
module kv_flow_table
   import kv_pkg::*;
#(
   parameter int KEY_SIZE = 96,
   parameter int TBL_AW   = 10,
   parameter int CNT_W    = 32
) (
   input  logic                clk156,
   input  logic                eth_rst_n,
   input  logic [KEY_SIZE-1:0] in_key,
   input  logic [3:0]          in_flag,
   input  logic                in_valid,
   output logic                out_valid,
   output logic [3:0]          out_flag,
   output logic                init_done,
   output logic [CNT_W-1:0]    hit_cnt,
   output logic [CNT_W-1:0]    miss_cnt,
   output logic [CNT_W-1:0]    drop_cnt
);

   localparam int DW = KEY_SIZE + 1;
   localparam logic [TBL_AW-1:0] LAST_ADDR = '1;

   kv_state_t         state, state_nxt;
   logic [TBL_AW-1:0] init_addr;

   kv_op_t            in_op;
   logic [TBL_AW-1:0] in_idx;
   logic              in_acc;

   logic              s1_valid;
   kv_op_t            s1_op;
   logic [KEY_SIZE-1:0] s1_key;
   logic [TBL_AW-1:0] s1_idx;

   logic              s2_valid, s2_lookup, s2_we;
   logic [3:0]        s2_flag;
   logic [TBL_AW-1:0] s2_idx;
   logic [DW-1:0]     s2_wdata;

   logic              s3_we;
   logic [TBL_AW-1:0] s3_idx;
   logic [DW-1:0]     s3_wdata;

   logic              ram_we;
   logic [TBL_AW-1:0] ram_waddr;
   logic [DW-1:0]     ram_wdata, ram_rdata;

   logic [DW-1:0]     entry;
   logic              entry_valid, key_match, cmp_we;
   logic [3:0]        cmp_flag;
   logic [DW-1:0]     cmp_wdata;

   assign in_op  = kv_decode(in_flag);
   assign in_idx = TBL_AW'(kv_hash(KV_KEY_MAX'(in_key), KEY_SIZE, TBL_AW));
   assign in_acc = in_valid && (state == ST_RUN) && (in_op != OPC_NONE);

   always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
         state     <= ST_INIT;
         init_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) init_addr <= init_addr + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_INIT && init_addr == LAST_ADDR) state_nxt = ST_RUN;
   end

   always_comb begin
      init_done = (state == ST_RUN);
      ram_we    = s2_we;
      ram_waddr = s2_idx;
      ram_wdata = s2_wdata;
      if (state == ST_INIT) begin
         ram_we    = 1'b1;
         ram_waddr = init_addr;
         ram_wdata = '0;
      end
   end

   kv_tbl_ram #(.AW(TBL_AW), .DW(DW)) u_ram (
      .clk156 (clk156),
      .we     (ram_we),
      .waddr  (ram_waddr),
      .wdata  (ram_wdata),
      .raddr  (in_idx),
      .rdata  (ram_rdata)
   );

   // The S2 write lands after the younger request's read, and the write one
   // cycle older lands on the same edge as that read; both are bypassed.
   // NOTE: every always_comb output gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      entry = ram_rdata;
      if (s2_we && s2_idx == s1_idx)      entry = s2_wdata;
      else if (s3_we && s3_idx == s1_idx) entry = s3_wdata;
      entry_valid = entry[KEY_SIZE];
      key_match   = entry_valid && (entry[KEY_SIZE-1:0] == s1_key);
      cmp_flag    = '0;
      cmp_we      = 1'b0;
      cmp_wdata   = {1'b1, s1_key};
      case (s1_op)
         OPC_LOOKUP: cmp_flag[RES_HIT] = key_match;
         OPC_INSERT: begin
            cmp_flag[RES_HIT]       = key_match;
            cmp_flag[RES_WRITTEN]   = 1'b1;
            cmp_flag[RES_COLLISION] = entry_valid && !key_match;
            cmp_we                  = s1_valid;
         end
         OPC_DELETE: begin
            cmp_flag[RES_HIT]     = key_match;
            cmp_flag[RES_REMOVED] = key_match;
            cmp_we                = s1_valid && key_match;
            cmp_wdata             = {1'b0, s1_key};
         end
         default: ;
      endcase
   end

   // NOTE: state registers use <= only, so every stage samples the values of
   // the previous cycle regardless of statement order.
   always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= OPC_NONE;
         s1_key    <= '0;
         s1_idx    <= '0;
         s2_valid  <= 1'b0;
         s2_lookup <= 1'b0;
         s2_we     <= 1'b0;
         s2_flag   <= '0;
         s2_idx    <= '0;
         s2_wdata  <= '0;
         s3_we     <= 1'b0;
         s3_idx    <= '0;
         s3_wdata  <= '0;
         out_valid <= 1'b0;
         out_flag  <= '0;
      end else begin
         s1_valid <= in_acc;
         if (in_acc) begin
            s1_op  <= in_op;
            s1_key <= in_key;
            s1_idx <= in_idx;
         end
         s2_valid  <= s1_valid;
         s2_lookup <= (s1_op == OPC_LOOKUP);
         s2_we     <= cmp_we;
         s2_flag   <= cmp_flag;
         s2_idx    <= s1_idx;
         s2_wdata  <= cmp_wdata;
         s3_we     <= s2_we;
         s3_idx    <= s2_idx;
         s3_wdata  <= s2_wdata;
         out_valid <= s2_valid;
         out_flag  <= s2_valid ? s2_flag : 4'b0000;
      end
   end

   // Counters move on the edge that raises out_valid, so they are current
   // while the result is presented.
   always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (s2_valid && s2_flag[RES_HIT])              hit_cnt  <= hit_cnt + 1'b1;
         if (s2_valid && s2_lookup && !s2_flag[RES_HIT]) miss_cnt <= miss_cnt + 1'b1;
         if (in_valid && state == ST_INIT)              drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_kv_flow_table.sv
// Scoreboard bench for kv_flow_table with a 16-entry table: stimulus pushes
// hand-computed results, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_kv_flow_table;

   localparam logic [3:0] LK  = 4'b0001;
   localparam logic [3:0] INS = 4'b0010;
   localparam logic [3:0] DEL = 4'b0100;

   typedef struct {
      string      name;
      logic [3:0] flag;
      int         due;
   } exp_t;

   logic        clk156 = 1'b0;
   logic        eth_rst_n;
   logic [95:0] in_key;
   logic [3:0]  in_flag;
   logic        in_valid;
   logic        out_valid;
   logic [3:0]  out_flag;
   logic        init_done;
   logic [31:0] hit_cnt, miss_cnt, drop_cnt;

   int   checks = 0;
   int   errors = 0;
   int   pcyc   = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   kv_flow_table #(.KEY_SIZE(96), .TBL_AW(4), .CNT_W(32)) dut (
      .clk156    (clk156),
      .eth_rst_n (eth_rst_n),
      .in_key    (in_key),
      .in_flag   (in_flag),
      .in_valid  (in_valid),
      .out_valid (out_valid),
      .out_flag  (out_flag),
      .init_done (init_done),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #3 clk156 = ~clk156;
   always @(posedge clk156) pcyc <= pcyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk156) begin
      if (out_valid !== 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got out_valid=%b flag=%b expected no result at cycle %0d",
                     out_valid, out_flag, pcyc);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_flag"}, 64'(out_flag), 64'(mon_e.flag));
            check({mon_e.name, "_latency"}, 64'(pcyc), 64'(mon_e.due));
         end
      end
   end

   task automatic req(input logic [3:0] flag, input logic [95:0] key, input string name,
                      input logic [3:0] exp_flag, input bit expect_out);
      @(negedge clk156);
      in_valid = 1'b1;
      in_flag  = flag;
      in_key   = key;
      if (expect_out) exp_q.push_back('{name, exp_flag, pcyc + 3});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk156);
         in_valid = 1'b0;
         in_flag  = 4'b0000;
      end
   endtask

   task automatic drain(input string name);
      idle(6);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_missing: got %0d results outstanding expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic init_sweep(input string name);
      repeat (14) @(negedge clk156);
      check({name, "_init_low_15"}, 64'(init_done), 64'd0);
      @(negedge clk156);
      check({name, "_init_high_16"}, 64'(init_done), 64'd1);
   endtask

   initial begin
      eth_rst_n = 1'b0;
      in_valid  = 1'b0;
      in_flag   = 4'b0000;
      in_key    = '0;
      repeat (3) @(negedge clk156);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_flag", 64'(out_flag), 64'd0);
      check("rst_init_done", 64'(init_done), 64'd0);
      check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

      // 1: sweep, with a LOOKUP arriving during INIT
      @(negedge clk156);
      eth_rst_n = 1'b1;
      in_valid  = 1'b1;
      in_flag   = LK;
      in_key    = 96'hA5;
      @(negedge clk156);
      in_valid = 1'b0;
      in_flag  = 4'b0000;
      init_sweep("t1");
      check("t1_drop_cnt", 64'(drop_cnt), 64'd1);

      // 2: INSERT then LOOKUP three cycles later; reserved-only flag yields nothing
      req(INS, 96'hA5, "t2_insert", 4'b0010, 1'b1);
      idle(2);
      req(LK, 96'hA5, "t2_lookup", 4'b0001, 1'b1);
      req(4'b1000, 96'hA5, "t2_reserved", 4'b0000, 1'b0);
      drain("t2");
      check("t2_hit_cnt", 64'(hit_cnt), 64'd1);
      check("t2_miss_cnt", 64'(miss_cnt), 64'd0);

      // 3: back-to-back INSERT/LOOKUP of one key (slot 2)
      req(INS, 96'h2, "t3_insert", 4'b0010, 1'b1);
      req(LK, 96'h2, "t3_lookup", 4'b0001, 1'b1);
      drain("t3");
      check("t3_hit_cnt", 64'(hit_cnt), 64'd2);

      // 4: K1=1 and K2=0x10 both hash to slot 1
      req(INS, 96'h1, "t4_insert_k1", 4'b0010, 1'b1);
      idle(1);
      req(INS, 96'h10, "t4_insert_k2", 4'b1010, 1'b1);
      req(LK, 96'h1, "t4_lookup_k1", 4'b0000, 1'b1);
      drain("t4");
      check("t4_miss_cnt", 64'(miss_cnt), 64'd1);
      check("t4_hit_cnt", 64'(hit_cnt), 64'd2);

      // 5: delete (DELETE outranks INSERT/LOOKUP), delete again, lookup
      req(INS, 96'h5, "t5_insert", 4'b0010, 1'b1);
      idle(2);
      req(4'b0111, 96'h5, "t5_delete", 4'b0101, 1'b1);
      idle(1);
      req(DEL, 96'h5, "t5_delete_again", 4'b0000, 1'b1);
      req(LK, 96'h5, "t5_lookup", 4'b0000, 1'b1);
      drain("t5");
      check("t5_hit_cnt", 64'(hit_cnt), 64'd3);
      check("t5_miss_cnt", 64'(miss_cnt), 64'd2);

      // 6: reset with three requests in flight
      req(INS, 96'h7, "t6_a", 4'b0000, 1'b0);
      req(LK, 96'h7, "t6_b", 4'b0000, 1'b0);
      req(INS, 96'h9, "t6_c", 4'b0000, 1'b0);
      @(posedge clk156);
      #1;
      eth_rst_n = 1'b0;
      in_valid  = 1'b0;
      in_flag   = 4'b0000;
      #1;
      check("t6_out_valid_now", 64'(out_valid), 64'd0);
      check("t6_hit_cnt", 64'(hit_cnt), 64'd0);
      check("t6_miss_cnt", 64'(miss_cnt), 64'd0);
      check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
      check("t6_init_done", 64'(init_done), 64'd0);
      repeat (2) @(negedge clk156);
      eth_rst_n = 1'b1;
      @(negedge clk156);
      init_sweep("t6");
      req(LK, 96'hA5, "t6_lookup_a5", 4'b0000, 1'b1);
      req(LK, 96'h2, "t6_lookup_2", 4'b0000, 1'b1);
      drain("t6");
      check("t6_post_miss_cnt", 64'(miss_cnt), 64'd2);
      check("t6_post_hit_cnt", 64'(hit_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
